im_loader: RTL
==============

# im_loader

Boot-time instruction-memory writer: receives a byte stream over a valid/ready handshake and writes it, one 32-bit word per cycle, into the instruction-memory block on its write port (`wea`, `addra`, `dina`). It is the write-side counterpart of the fetch stage, which only reads that memory with `wea` tied to 0. While a load is in progress it holds the CPU in reset through `CpuHold`, and releases the CPU only after a checksum-verified load.

## Interface
Parameters:
- `IM_DEPTH`, 2048: instruction-memory depth in words (PC 0x3000–0x4fff).
- `ADDR_W`, 11: width of `addra`.
- `TIMEOUT`, 1000000: maximum idle cycles between bytes during a load before an error; 0 disables the timeout.

Ports:
- `clk`, in, 1: the single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `Start`, in, 1: one-cycle pulse that re-arms the loader from DONE or ERR.
- `ByteValid`, in, 1: byte-stream valid.
- `ByteData`, in, 8: byte-stream data.
- `ByteReady`, out, 1: loader accepts a byte.
- `wea`, out, 4: IM byte-write enables; `4'b1111` for a write, else 0.
- `addra`, out, ADDR_W: IM word address.
- `dina`, out, 32: IM write data.
- `CpuHold`, out, 1: holds the CPU in reset while 1.
- `Done`, out, 1: load completed and verified.
- `ErrorCode`, out, 2: 00 none, 01 oversize, 10 checksum, 11 timeout.

## Operation
- A byte is accepted on any cycle where `ByteValid && ByteReady`.
- Frame format: COUNT_HI, COUNT_LO (16-bit word count N, big-endian), then N words of 4 bytes each (big-endian, first byte → `dina[31:24]`), then one CHECK byte.
- CHECK must equal the XOR of every preceding byte in the frame, header included.
- States:
  - HDR0: accept COUNT_HI → HDR1.
  - HDR1: accept COUNT_LO.
    - N > IM_DEPTH → ERR, code 01.
    - N == 0 → CHECK.
    - Otherwise → DATA.
  - DATA: shift bytes into a 32-bit assembly register. On the 4th byte of a word, issue a write with `addra` = word index (0 → PC 0x3000) and increment the index. After word N-1 → CHECK.
  - CHECK: accept one byte.
    - Match → DONE.
    - Mismatch → ERR, code 10.
  - DONE: `Done`=1, `CpuHold`=0. `Start` → HDR0.
  - ERR: `ErrorCode` is held, `CpuHold`=1. `Start` → HDR0.
- `ByteReady`=1 in HDR0, HDR1, DATA and CHECK; 0 in DONE and ERR. No backpressure is needed because each write completes in one cycle.
- `Start` in any other state is ignored.
- On re-arm: word index, checksum accumulator and timeout counter are cleared, `ErrorCode` is cleared, `Done` drops, and `CpuHold` rises.
- Timeout (TIMEOUT ≠ 0):
  - The idle counter runs in HDR1, DATA and CHECK, and resets on every accepted byte.
  - HDR0 never times out, so a link may stay idle before a frame starts.
  - When the counter reaches TIMEOUT → ERR, code 11. A partially assembled word is discarded and not written.
- Words already written before an error are left in IM; the CPU stays held.

## Timing
- Reset values:
  - `wea`=0, `addra`=0, `dina`=0.
  - `CpuHold`=1, `Done`=0, `ErrorCode`=00.
  - `ByteReady`=1, state HDR0.
- Write latency: `wea`/`addra`/`dina` are registered and valid for exactly one cycle, in the cycle after the 4th byte of a word is accepted.
- Back-to-back bytes at one per cycle are sustained, giving one write every 4 cycles at full rate.
- DONE entry: `Done`=1 and `CpuHold`=0 in the cycle after CHECK is accepted. The final data write occurs at least one cycle before this.
- ERR entry for code 01: registered in the cycle after COUNT_LO. No write is ever issued.
- Reset asserted mid-load: all outputs take their reset values immediately (asynchronously), and any pending write is dropped.
- Maximum N = 2048: the last write goes to `addra` = 0x7FF. The index never wraps.

## Structure
- Shared package `im_loader_pkg`:
  - state encoding (HDR0, HDR1, DATA, CHECK, DONE, ERR);
  - error-code constants (ERR_NONE, ERR_SIZE, ERR_CSUM, ERR_TIMEOUT);
  - `IM_DEPTH`;
  - IM base PC 0x3000.
- One natural sub-module, `im_loader_timer`: the idle counter, with clear/enable inputs and an expire output. It is instantiated only when TIMEOUT ≠ 0.
- Everything else (FSM, byte assembler, index counter, XOR accumulator) lives in the top module.

## Test plan
- Good frame: bytes 00 02 3C 01 00 00 34 21 00 04 2E at full rate → writes addr 0 = 0x3C010000 and addr 1 = 0x34210004, one cycle each; then `Done`=1, `CpuHold`=0, `ErrorCode`=00.
- Same frame with CHECK = 2F → both writes still occur; `ErrorCode`=10, `CpuHold`=1, `ByteReady`=0, `Done`=0.
- Header 08 01 → ERR with code 01 the cycle after the second byte; `wea` never asserted.
- Empty frame 00 00 00 → DONE with no writes; `ByteValid` toggled randomly gives the same result.
- TIMEOUT=16: send 00 01 12 34 56, then stay idle → ERR with code 11 after 16 idle cycles; no write issued. Then pulse `Start` and send a good frame → DONE.
- Assert `reset` during DATA of a 4-word frame → outputs take reset values immediately. Release `reset`, then send the full good frame → correct writes and DONE.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package im_loader_pkg;

  // Loader states.
  typedef enum logic [2:0] {
    StHdr0,
    StHdr1,
    StData,
    StCheck,
    StDone,
    StErr
  } state_e;

  // Error codes reported on ErrorCode.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SIZE    = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Instruction-memory depth in words and the PC that word 0 maps to.
  localparam int unsigned IM_DEPTH   = 2048;
  localparam logic [15:0] IM_BASE_PC = 16'h3000;

endpackage

// File: rtl/im_loader_timer.sv
// Idle-cycle counter: counts enabled cycles since the last clear and flags when
// the count reaches Limit. Holds at Limit until cleared.
module im_loader_timer #(
  parameter int unsigned Limit = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (Limit < 2) ? 1 : $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q;

  assign expire_o = (cnt_q == CntW'(Limit));

  // Idle count: clear wins, otherwise count up while enabled and not yet expired.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory writer. Parses a framed byte stream
// (16-bit word count, big-endian words, XOR check byte), writes each word to
// the IM write port and holds the CPU until a verified load completes.
module im_loader #(
  parameter int unsigned IM_DEPTH = im_loader_pkg::IM_DEPTH,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              ByteValid,
  input  logic [7:0]        ByteData,
  output logic              ByteReady,
  output logic [3:0]        wea,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  output logic              CpuHold,
  output logic              Done,
  output logic [1:0]        ErrorCode
);

  import im_loader_pkg::*;

  localparam logic [15:0] DepthLim = 16'(IM_DEPTH);

  state_e      state_q;
  logic [7:0]  hdr_hi_q;
  logic [15:0] n_q;
  logic [15:0] wcnt_q;
  logic [1:0]  bcnt_q;
  logic [23:0] asm_q;
  logic [7:0]  csum_q;

  logic        accept;
  logic        cnt_en;
  logic        cnt_clr;
  logic        expire;
  logic [15:0] n_rx;
  logic [15:0] wcnt_nxt;
  logic [7:0]  csum_nxt;

  // Handshake, header decode and idle-timer control.
  always_comb begin
    accept   = ByteValid & ByteReady;
    cnt_en   = (state_q == StHdr1) || (state_q == StData) || (state_q == StCheck);
    cnt_clr  = accept | ~cnt_en;
    n_rx     = {hdr_hi_q, ByteData};
    wcnt_nxt = wcnt_q + 16'd1;
    csum_nxt = csum_q ^ ByteData;
  end

  if (TIMEOUT != 0) begin : g_timer
    im_loader_timer #(
      .Limit(TIMEOUT)
    ) u_timer (
      .clk_i   (clk),
      .rst_ni  (reset),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .expire_o(expire)
    );
  end else begin : g_no_timer
    assign expire = 1'b0;
  end

  // Loader FSM with byte assembler, word index, XOR accumulator and all
  // registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StHdr0;
      hdr_hi_q  <= '0;
      n_q       <= '0;
      wcnt_q    <= '0;
      bcnt_q    <= '0;
      asm_q     <= '0;
      csum_q    <= '0;
      ByteReady <= 1'b1;
      wea       <= 4'b0000;
      addra     <= '0;
      dina      <= '0;
      CpuHold   <= 1'b1;
      Done      <= 1'b0;
      ErrorCode <= ERR_NONE;
    end else begin
      wea <= 4'b0000;
      unique case (state_q)
        StHdr0: begin
          if (accept) begin
            hdr_hi_q <= ByteData;
            csum_q   <= ByteData;
            state_q  <= StHdr1;
          end
        end
        StHdr1: begin
          if (accept) begin
            n_q    <= n_rx;
            csum_q <= csum_nxt;
            if (n_rx > DepthLim) begin
              state_q   <= StErr;
              ErrorCode <= ERR_SIZE;
              ByteReady <= 1'b0;
            end else if (n_rx == 16'd0) begin
              state_q <= StCheck;
            end else begin
              state_q <= StData;
            end
          end else if (expire) begin
            state_q   <= StErr;
            ErrorCode <= ERR_TIMEOUT;
            ByteReady <= 1'b0;
          end
        end
        StData: begin
          if (accept) begin
            csum_q <= csum_nxt;
            if (bcnt_q == 2'd3) begin
              wea    <= 4'b1111;
              addra  <= wcnt_q[ADDR_W-1:0];
              dina   <= {asm_q, ByteData};
              wcnt_q <= wcnt_nxt;
              bcnt_q <= 2'd0;
              if (wcnt_nxt == n_q) begin
                state_q <= StCheck;
              end
            end else begin
              asm_q  <= {asm_q[15:0], ByteData};
              bcnt_q <= bcnt_q + 2'd1;
            end
          end else if (expire) begin
            // Partial word is simply abandoned; no write is issued.
            state_q   <= StErr;
            ErrorCode <= ERR_TIMEOUT;
            ByteReady <= 1'b0;
          end
        end
        StCheck: begin
          if (accept) begin
            ByteReady <= 1'b0;
            if (ByteData == csum_q) begin
              state_q <= StDone;
              Done    <= 1'b1;
              CpuHold <= 1'b0;
            end else begin
              state_q   <= StErr;
              ErrorCode <= ERR_CSUM;
            end
          end else if (expire) begin
            state_q   <= StErr;
            ErrorCode <= ERR_TIMEOUT;
            ByteReady <= 1'b0;
          end
        end
        StDone, StErr: begin
          if (Start) begin
            state_q   <= StHdr0;
            wcnt_q    <= '0;
            bcnt_q    <= '0;
            csum_q    <= '0;
            ErrorCode <= ERR_NONE;
            Done      <= 1'b0;
            CpuHold   <= 1'b1;
            ByteReady <= 1'b1;
          end
        end
        default: begin
          state_q <= StHdr0;
        end
      endcase
    end
  end

endmodule
